// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline (fetch + data ports), the arbiter and the
// unified single-ported memory.
interface mem_port_arbiter_if #(
  parameter int DW = 32
) ();
  // fetch port
  logic          if_req;
  logic [DW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          if_stall;
  // data (MEM-stage) port
  logic          d_req;
  logic          d_we;
  logic [DW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          d_stall;
  // memory side
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_valid;
  // timeout indication
  logic          err;

  // Arbiter view: serves both pipeline ports and masters the memory.
  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_valid,
    output if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );

  // Environment view: the pipeline requesters and the memory itself.
  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_valid,
    input  if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and the
// MEM-stage data port. Data has priority, but after MAX_DPRIO consecutive data
// grants taken while fetch was waiting, fetch wins the next contended round.
// Each access runs IDLE -> ISSUE -> WAIT -> RESP; a memory that never answers
// is cut off after TIMEOUT wait cycles with 32'hDEADBEEF and an err pulse.
module mem_port_arbiter #(
  parameter int DW        = 32,
  parameter int MAX_DPRIO = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [3:0]    DPRIO_MAX = 4'(MAX_DPRIO);
  localparam logic [7:0]    WAIT_MAX  = 8'(TIMEOUT);
  localparam logic [DW-1:0] ERR_DATA  = DW'(32'hDEADBEEF);

  state_t        state_reg, state_next;
  logic          owner_d_reg, owner_d_next;       // 1: data port owns the access
  logic [3:0]    starve_cnt_reg, starve_cnt_next;
  logic [7:0]    wait_cnt_reg, wait_cnt_next;
  logic [DW-1:0] if_rdata_reg, if_rdata_next;
  logic [DW-1:0] d_rdata_reg, d_rdata_next;
  logic          if_ready_reg, if_ready_next;
  logic          d_ready_reg, d_ready_next;
  logic          err_reg, err_next;
  logic          mem_req_reg, mem_req_next;
  logic          mem_we_reg, mem_we_next;
  logic [DW-1:0] mem_addr_reg, mem_addr_next;
  logic [DW-1:0] mem_wdata_reg, mem_wdata_next;

  logic          grant_d;
  logic          resp_done;
  logic          resp_err;
  logic [DW-1:0] resp_data;

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_next      = state_reg;
    owner_d_next    = owner_d_reg;
    starve_cnt_next = starve_cnt_reg;
    wait_cnt_next   = wait_cnt_reg;
    if_rdata_next   = if_rdata_reg;
    d_rdata_next    = d_rdata_reg;
    if_ready_next   = 1'b0;
    d_ready_next    = 1'b0;
    err_next        = 1'b0;
    mem_req_next    = 1'b0;
    mem_we_next     = mem_we_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    grant_d         = 1'b0;
    resp_done       = 1'b0;
    resp_err        = 1'b0;
    resp_data       = '0;

    case (state_reg)
      S_IDLE: begin
        if (bus.if_req || bus.d_req) begin
          // Data wins unless fetch has already been passed over MAX_DPRIO times.
          grant_d      = bus.d_req && !(bus.if_req && (starve_cnt_reg == DPRIO_MAX));
          owner_d_next = grant_d;
          if (grant_d) begin
            mem_we_next    = bus.d_we;
            mem_addr_next  = bus.d_addr;
            mem_wdata_next = bus.d_wdata;
            if (bus.if_req && (starve_cnt_reg != DPRIO_MAX)) begin
              starve_cnt_next = starve_cnt_reg + 4'd1;
            end
          end else begin
            mem_we_next     = 1'b0;
            mem_addr_next   = bus.if_addr;
            mem_wdata_next  = '0;
            starve_cnt_next = '0;
          end
          mem_req_next = 1'b1;
          state_next   = S_ISSUE;
        end
      end

      S_ISSUE: begin
        // The first WAIT cycle counts as wait cycle 1.
        wait_cnt_next = 8'd1;
        state_next    = S_WAIT;
      end

      S_WAIT: begin
        // A completion in the final wait cycle still beats the timeout.
        if (bus.mem_valid) begin
          resp_done = 1'b1;
          resp_data = mem_we_reg ? '0 : bus.mem_rdata;
        end else if (wait_cnt_reg == WAIT_MAX) begin
          resp_done = 1'b1;
          resp_err  = 1'b1;
          resp_data = ERR_DATA;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
        if (resp_done) begin
          state_next = S_RESP;
          err_next   = resp_err;
          if (owner_d_reg) begin
            d_ready_next = 1'b1;
            d_rdata_next = resp_data;
          end else begin
            if_ready_next = 1'b1;
            if_rdata_next = resp_data;
          end
        end
      end

      S_RESP: begin
        wait_cnt_next = '0;
        state_next    = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  // State and registered-output update; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      owner_d_reg    <= 1'b0;
      starve_cnt_reg <= '0;
      wait_cnt_reg   <= '0;
      if_rdata_reg   <= '0;
      d_rdata_reg    <= '0;
      if_ready_reg   <= 1'b0;
      d_ready_reg    <= 1'b0;
      err_reg        <= 1'b0;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      owner_d_reg    <= owner_d_next;
      starve_cnt_reg <= starve_cnt_next;
      wait_cnt_reg   <= wait_cnt_next;
      if_rdata_reg   <= if_rdata_next;
      d_rdata_reg    <= d_rdata_next;
      if_ready_reg   <= if_ready_next;
      d_ready_reg    <= d_ready_next;
      err_reg        <= err_next;
      mem_req_reg    <= mem_req_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
    end
  end

  assign bus.if_rdata  = if_rdata_reg;
  assign bus.if_ready  = if_ready_reg;
  assign bus.d_rdata   = d_rdata_reg;
  assign bus.d_ready   = d_ready_reg;
  assign bus.err       = err_reg;
  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;

  // Stalls are combinational so the pipeline releases in the ready cycle.
  assign bus.if_stall  = bus.if_req & ~if_ready_reg;
  assign bus.d_stall   = bus.d_req & ~d_ready_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Stimulus pushes expected memory
// accesses and expected responses into queues; a negedge monitor pops and
// compares whenever the DUT strobes mem_req or a ready.
module tb_mem_port_arbiter;
  localparam int DW        = 32;
  localparam int MAX_DPRIO = 4;
  localparam int TIMEOUT   = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.DW(DW)) bus ();

  mem_port_arbiter #(
    .DW(DW),
    .MAX_DPRIO(MAX_DPRIO),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    bit          err;
    int          at_cyc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
  } acc_t;

  resp_t resp_q[$];
  acc_t  acc_q[$];

  // memory model configuration (written only by the stimulus process)
  int          mem_delay = 0;      // -1: never respond
  logic [31:0] mem_data  = '0;
  int          stray_at  = -1;     // cycle for an unsolicited mem_valid

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_acc(input logic [31:0] addr, input bit we, input logic [31:0] wdata);
    acc_t a;
    a.addr  = addr;
    a.we    = we;
    a.wdata = wdata;
    acc_q.push_back(a);
  endtask

  task automatic push_resp(input bit is_d, input logic [31:0] rdata, input bit err, input int at_cyc);
    resp_t r;
    r.is_d   = is_d;
    r.rdata  = rdata;
    r.err    = err;
    r.at_cyc = at_cyc;
    resp_q.push_back(r);
  endtask

  task automatic wait_ready(input bit is_d, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (is_d ? bus.d_ready : bus.if_ready) return;
    end
    fail("wait ready: got no ready pulse, expected one");
  endtask

  // One complete access; lat is the expected cycle of the ready pulse.
  task automatic access(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int delay,
                        input logic [31:0] mdata, input logic [31:0] exp_rdata,
                        input bit exp_err, input int lat, input bit scramble);
    mem_delay = delay;
    mem_data  = mdata;
    push_acc(addr, we, wdata);
    push_resp(is_d, exp_rdata, exp_err, cyc + lat);
    if (is_d) begin
      bus.d_req   = 1'b1;
      bus.d_we    = we;
      bus.d_addr  = addr;
      bus.d_wdata = wdata;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
    end
    if (scramble) begin
      // inputs change after the grant and must not reach the memory
      step();
      step();
      bus.d_addr  = 32'hFFF0;
      bus.d_wdata = 32'h11111111;
    end
    wait_ready(is_d, lat + 20);
    step();
    bus.d_req  = 1'b0;
    bus.if_req = 1'b0;
    bus.d_we   = 1'b0;
    step();
  endtask

  // Memory model: answers each mem_req after mem_delay extra cycles.
  initial begin
    int pend;
    pend          = -1;
    bus.mem_valid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_valid = 1'b0;
      if (reset) pend = -1;
      if (pend == 0) begin
        bus.mem_valid = 1'b1;
        bus.mem_rdata = mem_data;
        pend          = -1;
      end else if (pend > 0) begin
        pend--;
      end
      if (cyc == stray_at) begin
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h0BADF00D;
      end
      if (bus.mem_req && !reset) pend = mem_delay;
    end
  end

  // Monitor: checks every memory strobe and every ready against the queues.
  initial begin
    logic [31:0] h_addr;
    logic [31:0] h_wdata;
    bit          inflight;
    acc_t        a;
    resp_t       r;
    inflight = 1'b0;
    h_addr   = '0;
    h_wdata  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        inflight = 1'b0;
      end else begin
        if (bus.mem_req) begin
          if (acc_q.size() == 0) begin
            fail("mem_req: got a strobe, expected none");
          end else begin
            a = acc_q.pop_front();
            chk("mem_addr", bus.mem_addr, a.addr);
            chk("mem_we", 32'(bus.mem_we), 32'(a.we));
            if (a.we) chk("mem_wdata", bus.mem_wdata, a.wdata);
          end
          h_addr   = bus.mem_addr;
          h_wdata  = bus.mem_wdata;
          inflight = 1'b1;
        end else if (inflight && !(bus.if_ready || bus.d_ready)) begin
          chk("mem_addr hold", bus.mem_addr, h_addr);
          chk("mem_wdata hold", bus.mem_wdata, h_wdata);
        end

        if (bus.if_ready || bus.d_ready) begin
          inflight = 1'b0;
          chk("ready exclusive", 32'(bus.if_ready & bus.d_ready), 32'd0);
          if (resp_q.size() == 0) begin
            fail("ready: got a ready pulse, expected none");
          end else begin
            r = resp_q.pop_front();
            chk("ready port", 32'(bus.d_ready), 32'(r.is_d));
            chk("rdata", bus.d_ready ? bus.d_rdata : bus.if_rdata, r.rdata);
            chk("err", 32'(bus.err), 32'(r.err));
            chk("ready cycle", 32'(cyc), 32'(r.at_cyc));
            $display("resp port=%s rdata=%h err=%0d cycle=%0d",
                     bus.d_ready ? "D" : "I",
                     bus.d_ready ? bus.d_rdata : bus.if_rdata, bus.err, cyc);
          end
        end else begin
          chk("err idle", 32'(bus.err), 32'd0);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int t0;
    int seen;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst if_ready", 32'(bus.if_ready), 32'd0);
    chk("rst d_ready", 32'(bus.d_ready), 32'd0);
    chk("rst err", 32'(bus.err), 32'd0);
    chk("rst mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst mem_addr", bus.mem_addr, 32'd0);
    chk("rst mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst if_rdata", bus.if_rdata, 32'd0);
    chk("rst d_rdata", bus.d_rdata, 32'd0);
    chk("rst stalls", {30'd0, bus.if_stall, bus.d_stall}, 32'd0);
    step();
    reset = 1'b0;
    step();

    // single load: mem_req at cycle 1, ready at cycle 3, stall in cycles 0..2
    $display("txn single load");
    mem_delay = 0;
    mem_data  = 32'h12345678;
    push_acc(32'h40, 1'b0, 32'h0);
    t0 = cyc;
    push_resp(1'b1, 32'h12345678, 1'b0, t0 + 3);
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h40;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("load d_stall", 32'(bus.d_stall), (k < 3) ? 32'd1 : 32'd0);
      chk("load mem_req", 32'(bus.mem_req), (k == 1) ? 32'd1 : 32'd0);
    end
    step();
    bus.d_req = 1'b0;
    step();

    // contention: both held, expect D,D,D,D,I,D,D,D,D,I every 4 cycles
    $display("txn contention");
    mem_delay = 0;
    mem_data  = 32'hA5A50000;
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      push_acc(((i % 5) != 4) ? 32'h200 : 32'h100, 1'b0, 32'h0);
      push_resp((i % 5) != 4, 32'hA5A50000, 1'b0, t0 + 3 + 4 * i);
    end
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h200;
    seen = 0;
    for (int i = 0; i < 60 && seen < 10; i++) begin
      @(negedge clk);
      if (bus.if_ready || bus.d_ready) seen++;
    end
    chk("contention grants", 32'(seen), 32'd10);
    step();
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    step();

    // store with 5 extra wait cycles; inputs disturbed after the grant
    $display("txn store");
    access(1'b1, 1'b1, 32'h80, 32'hCAFEF00D, 5, 32'h77777777, 32'h0, 1'b0, 8, 1'b1);

    // fetch timeout, then a normal fetch
    $display("txn timeout");
    access(1'b0, 1'b0, 32'h300, 32'h0, -1, 32'h0, 32'hDEADBEEF, 1'b1, 2 + TIMEOUT, 1'b0);
    $display("txn fetch after timeout");
    access(1'b0, 1'b0, 32'h304, 32'h0, 0, 32'h87654321, 32'h87654321, 1'b0, 3, 1'b0);

    // mem_valid in the very cycle the timeout is reached
    $display("txn valid at timeout");
    access(1'b1, 1'b0, 32'h44, 32'h0, TIMEOUT - 1, 32'h5555AAAA, 32'h5555AAAA, 1'b0, 2 + TIMEOUT, 1'b0);

    // reset mid-WAIT followed by a stray mem_valid
    $display("txn reset mid-wait");
    mem_delay = -1;
    push_acc(32'h48, 1'b0, 32'h0);
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h48;
    repeat (10) step();
    reset     = 1'b1;
    bus.d_req = 1'b0;
    step();
    reset    = 1'b0;
    stray_at = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post-rst d_ready", 32'(bus.d_ready), 32'd0);
      chk("post-rst mem_req", 32'(bus.mem_req), 32'd0);
      chk("post-rst mem_addr", bus.mem_addr, 32'd0);
      chk("post-rst if_rdata", bus.if_rdata, 32'd0);
      chk("post-rst d_rdata", bus.d_rdata, 32'd0);
    end
    step();
    stray_at = -1;

    // next request completes normally
    $display("txn after reset");
    access(1'b1, 1'b0, 32'h4C, 32'h0, 1, 32'h0F0F0F0F, 32'h0F0F0F0F, 1'b0, 4, 1'b0);

    repeat (3) step();
    chk("resp queue drained", 32'(resp_q.size()), 32'd0);
    chk("access queue drained", 32'(acc_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish (cycle %0d)", cyc);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified memory between the pipeline's instruction-fetch port and its data-memory (MEM-stage) port. It arbitrates requests with data-port priority and a bounded-starvation guarantee for fetch, sequences each access through a fixed issue/wait/respond protocol, and produces per-port stall signals that feed the PC/IF-ID write enables and the EX/MEM/WB freeze. It also detects memory that never responds, ending the access with an error response.

## Interface
- `DW`, 32: data and address width.
- `MAX_DPRIO`, 4: consecutive data grants allowed while fetch waits; then fetch wins the next contended arbitration. Range 1..15.
- `TIMEOUT`, 64: WAIT cycles before an access is aborted. Range 2..255.

- `clk`  in  1  clock. Rising edge.
- `reset`  in  1  one clock, synchronous, active-high reset.
- `if_req`  in  1  fetch read request. Held until `if_ready`.
- `if_addr`  in  DW  fetch byte address.
- `if_rdata`  out  DW  fetch read data. Valid while `if_ready`.
- `if_ready`  out  1  one-cycle completion pulse for fetch.
- `if_stall`  out  1  `if_req & ~if_ready` (combinational).
- `d_req`  in  1  data request. Held until `d_ready`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  DW  data byte address.
- `d_wdata`  in  DW  store data.
- `d_rdata`  out  DW  load data. Valid while `d_ready`.
- `d_ready`  out  1  one-cycle completion pulse for data.
- `d_stall`  out  1  `d_req & ~d_ready` (combinational).
- `mem_req`  out  1  one-cycle access strobe to the memory.
- `mem_we`  out  1  write enable, qualified by `mem_req`.
- `mem_addr`  out  DW  access address. Held from ISSUE through WAIT.
- `mem_wdata`  out  DW  write data. Held from ISSUE through WAIT.
- `mem_rdata`  in  DW  read data, sampled when `mem_valid` is high in WAIT.
- `mem_valid`  in  1  completion from the memory, for reads and writes.
- `err`  out  1  one-cycle pulse, coincident with the ready pulse of a timed-out access.

## Operation
- FSM has four states: IDLE, ISSUE, WAIT, RESP. All outputs except the stalls are registered.
- IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise select the owner:
    - only one request pending: that port;
    - both pending: data, unless `starve_cnt == MAX_DPRIO`, in which case fetch.
  - Latch owner, address, write data and write enable (`if` port: we = 0). Go to ISSUE.
- ISSUE: `mem_req = 1` for exactly this cycle. Go to WAIT. `mem_valid` is ignored in ISSUE.
- WAIT:
  - On `mem_valid`: capture `mem_rdata` (reads only; writes return 0) into the owner's rdata register. Go to RESP.
  - If `wait_cnt` reaches `TIMEOUT` first: rdata = 32'hDEADBEEF, set the error flag, go to RESP.
- RESP:
  - Owner's ready = 1 for one cycle; `err` = 1 for one cycle if the access timed out.
  - The owner's request is ignored in this cycle.
  - Go to IDLE.
- Starvation counter (`starve_cnt`):
  - Increments on a data grant when `if_req` was also high.
  - Clears on any fetch grant.
  - Saturates at `MAX_DPRIO`.
- Outside RESP, rdata outputs hold their last value and ready is 0.
- `mem_valid` seen outside WAIT is dropped silently.

## Timing
- Reset values:
  - state IDLE;
  - all readies, `err`, `mem_req`, `mem_we` = 0;
  - `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` = 0;
  - counters = 0.
- Reset mid-access aborts it: no ready pulse, no `err`. The memory shares `reset`.
- Access latency, request seen in IDLE at cycle 0:
  - ISSUE at cycle 1;
  - `mem_valid` earliest at cycle 2;
  - ready at cycle 3.
  - General form: ready at 3 + (extra memory wait cycles).
- Best-case throughput: one access per 4 cycles.
- Timeout: if `mem_valid` never arrives, ready + `err` arrive at cycle 2 + `TIMEOUT`.
- Simultaneous `mem_valid` and timeout in the same cycle: `mem_valid` wins, no `err`.
- Request dropped before ready (protocol violation): the access completes anyway and the ready pulse is still emitted.
- Inputs are sampled only in IDLE. Changes to address or data after the grant have no effect.

## Test plan
- Single load: `d_req`, `d_addr` = 0x40, memory returns 0x12345678 with `mem_valid` on the cycle after `mem_req` -> `mem_req` at cycle 1 with `mem_addr` = 0x40, `d_ready` with `d_rdata` = 0x12345678 at cycle 3, `d_stall` high for cycles 0–2.
- Contention: `if_req` and `d_req` held continuously, `MAX_DPRIO` = 4 -> grant order D,D,D,D,I,D,D,D,D,I; `if_ready` never coincides with `d_ready`.
- Store: `d_we` = 1, `d_addr` = 0x80, `d_wdata` = 0xCAFEF00D, memory delays `mem_valid` by 5 cycles -> `mem_we` = 1 with `mem_wdata` = 0xCAFEF00D held through WAIT; `d_ready` at cycle 8; `d_rdata` = 0.
- Timeout: `if_req`, memory never asserts `mem_valid` -> `if_ready` and `err` at cycle 66 with `if_rdata` = 0xDEADBEEF; then back to IDLE.
- Reset mid-WAIT, then stray `mem_valid` after reset -> no ready, no `err`, FSM in IDLE; the next request completes normally.
- Boundary: `mem_valid` arrives in the same cycle the timeout is reached -> normal data returned, `err` = 0.
